// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command sequencer.
// Optional macro SD_CMD_CRC7_EN (used by the top) selects the computed CRC7 path.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND,
    POLL,
    CS_RELEASE,
    TRAIL,
    DONE
  } sd_state_e;

  localparam logic [7:0] SD_FILL_BYTE   = 8'hFF;
  localparam logic [1:0] SD_CMD_START   = 2'b01;
  localparam logic [7:0] SD_CMD0_CRC    = 8'h95;
  localparam logic [7:0] SD_CMD8_CRC    = 8'h87;
  localparam logic [7:0] SD_DEFAULT_CRC = 8'h01;
  localparam int         SD_FRAME_BYTES = 6;

  // One byte of MSB-first CRC7 (x^7 + x^3 + 1).
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Link between the command sequencer (master) and the SPI byte engine (slave).
interface sd_cmd_sequencer_if;
  logic       spi_start;
  logic [7:0] spi_txd;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_rxd;

  modport master (output spi_start, output spi_txd,
                  input  spi_busy, input spi_done, input spi_rxd);
  modport slave  (input  spi_start, input spi_txd,
                  output spi_busy, output spi_done, output spi_rxd);
endinterface

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator for SD command frames; cleared per command.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'd0;
    end else if (clear) begin
      crc <= 7'd0;
    end else if (byte_valid) begin
      crc <= crc7_byte(crc, data);
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Runs one SD SPI-mode command: CS, 6-byte frame, R1 poll, CS release, trail clocks.
// Define SD_CMD_CRC7_EN to compute the CRC byte instead of using the fixed table.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 8,
  parameter int TRAIL_BYTES  = 1
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_timeout,
  output logic [7:0]  resp_r1,
  output logic        sd_cs_n,
  sd_cmd_sequencer_if.master spi
);

  localparam logic [2:0] LAST_BYTE   = 3'(SD_FRAME_BYTES - 1);
  localparam logic [7:0] POLL_LIMIT  = 8'(RESP_TIMEOUT);
  localparam logic [1:0] TRAIL_LIMIT = 2'(TRAIL_BYTES);

  sd_state_e   state;
  logic [5:0]  index_q;
  logic [31:0] arg_q;
  logic [2:0]  byte_cnt;
  logic [7:0]  poll_cnt;
  logic [1:0]  trail_cnt;
  logic        pending;
  logic [7:0]  frame_byte;
  logic [7:0]  crc_byte;
  logic [7:0]  poll_next;
  logic [1:0]  trail_next;
  logic        can_issue;
  logic        xfer_done;
  logic        accept;

  // A new byte may only go out when the engine is idle and nothing is in flight.
  assign can_issue  = !pending && !spi.spi_busy && !spi.spi_done;
  assign xfer_done  = pending && spi.spi_done;
  assign accept     = (state == IDLE) && cmd_start;
  assign poll_next  = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
  assign trail_next = (trail_cnt == 2'd3) ? trail_cnt : trail_cnt + 2'd1;

`ifdef SD_CMD_CRC7_EN
  logic [6:0] crc7;

  sd_crc7 u_crc7 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .byte_valid ((state == SEND) && can_issue && (byte_cnt < LAST_BYTE)),
    .data       (frame_byte),
    .crc        (crc7)
  );

  assign crc_byte = {crc7, 1'b1};
`else
  always_comb begin
    crc_byte = SD_DEFAULT_CRC;
    if (index_q == 6'd0)      crc_byte = SD_CMD0_CRC;
    else if (index_q == 6'd8) crc_byte = SD_CMD8_CRC;
  end
`endif

  always_comb begin
    frame_byte = SD_FILL_BYTE;
    case (byte_cnt)
      3'd0:    frame_byte = {SD_CMD_START, index_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      3'd5:    frame_byte = crc_byte;
      default: frame_byte = SD_FILL_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_busy      <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_timeout   <= 1'b0;
      resp_r1       <= SD_FILL_BYTE;
      sd_cs_n       <= 1'b1;
      spi.spi_start <= 1'b0;
      spi.spi_txd   <= SD_FILL_BYTE;
      index_q       <= 6'd0;
      arg_q         <= 32'd0;
      byte_cnt      <= 3'd0;
      poll_cnt      <= 8'd0;
      trail_cnt     <= 2'd0;
      pending       <= 1'b0;
    end else begin
      spi.spi_start <= 1'b0;
      cmd_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            index_q     <= cmd_index;
            arg_q       <= cmd_arg;
            cmd_busy    <= 1'b1;
            cmd_timeout <= 1'b0;
            resp_r1     <= SD_FILL_BYTE;
            state       <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          sd_cs_n  <= 1'b0;
          byte_cnt <= 3'd0;
          state    <= SEND;
        end
        SEND: begin
          if (can_issue) begin
            spi.spi_start <= 1'b1;
            spi.spi_txd   <= frame_byte;
            pending       <= 1'b1;
          end else if (xfer_done) begin
            pending <= 1'b0;
            if (byte_cnt == LAST_BYTE) begin
              poll_cnt <= 8'd0;
              state    <= POLL;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        POLL: begin
          if (can_issue) begin
            spi.spi_start <= 1'b1;
            spi.spi_txd   <= SD_FILL_BYTE;
            pending       <= 1'b1;
          end else if (xfer_done) begin
            pending <= 1'b0;
            if (!spi.spi_rxd[7]) begin
              resp_r1     <= spi.spi_rxd;
              cmd_timeout <= 1'b0;
              sd_cs_n     <= 1'b1;
              state       <= CS_RELEASE;
            end else begin
              poll_cnt <= poll_next;
              if (poll_next >= POLL_LIMIT) begin
                resp_r1     <= SD_FILL_BYTE;
                cmd_timeout <= 1'b1;
                sd_cs_n     <= 1'b1;
                state       <= CS_RELEASE;
              end
            end
          end
        end
        CS_RELEASE: begin
          if (TRAIL_BYTES > 0) begin
            trail_cnt <= 2'd0;
            state     <= TRAIL;
          end else begin
            cmd_done <= 1'b1;
            state    <= DONE;
          end
        end
        TRAIL: begin
          if (can_issue) begin
            spi.spi_start <= 1'b1;
            spi.spi_txd   <= SD_FILL_BYTE;
            pending       <= 1'b1;
          end else if (xfer_done) begin
            pending   <= 1'b0;
            trail_cnt <= trail_next;
            if (trail_next >= TRAIL_LIMIT) begin
              cmd_done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          cmd_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
